// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Brief    : RISC-V load/store unit. Aligns and lane-replicates stores,
//            extends loads, and flags misaligned or illegal-size accesses.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        lsu_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [2:0]  r_size;
    logic [1:0]  r_off;

    logic        w_size_legal;
    logic        w_misaligned;
    logic        w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign core_stall_o = core_req_i && (r_state != c_DONE);

    always_comb begin
        w_size_legal = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wd         = core_wd_i;
        case (core_size_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_size_legal = 1'b1;
            default:                                w_size_legal = 1'b0;
        endcase
        case (core_size_i[1:0])
            2'b00: begin
                w_be = 4'b0001 << core_addr_i[1:0];
                w_wd = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
                w_misaligned = core_addr_i[0];
                w_be         = 4'b0011 << core_addr_i[1:0];
                w_wd         = {2{core_wd_i[15:0]}};
            end
            default: begin
                w_misaligned = |core_addr_i[1:0];
                w_be         = 4'b1111;
                w_wd         = core_wd_i;
            end
        endcase
        w_err = !w_size_legal || w_misaligned;
    end

    // Load lane selection uses the offset captured at request time.
    always_comb begin
        w_byte = mem_rd_i[7:0];
        case (r_off)
            2'd0:    w_byte = mem_rd_i[7:0];
            2'd1:    w_byte = mem_rd_i[15:8];
            2'd2:    w_byte = mem_rd_i[23:16];
            default: w_byte = mem_rd_i[31:24];
        endcase
        w_half = r_off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (r_size)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rd_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_IDLE;
            r_size     <= 3'd0;
            r_off      <= 2'd0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'b0000;
            mem_addr_o <= 32'd0;
            mem_wd_o   <= 32'd0;
            core_rd_o  <= 32'd0;
            lsu_err_o  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (core_req_i) begin
                        if (w_err) begin
                            lsu_err_o <= 1'b1;
                            core_rd_o <= 32'd0;
                            r_state   <= c_DONE;
                        end else begin
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= core_we_i;
                            mem_be_o   <= w_be;
                            mem_addr_o <= {core_addr_i[31:2], 2'b00};
                            mem_wd_o   <= w_wd;
                            r_size     <= core_size_i;
                            r_off      <= core_addr_i[1:0];
                            r_state    <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            core_rd_o <= w_load;
                        end
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    lsu_err_o <= 1'b0;
                    r_state   <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_lsu
// Brief    : Directed plus randomized self-checking bench for riscv_lsu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

    logic        clk_i;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        lsu_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_rd;

    riscv_lsu u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .lsu_err_o    (lsu_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[8*addr[1:0] +: 8];
        h = rdata[16*addr[1] +: 16];
        case (size)
            3'b000:  return int'($signed(b));
            3'b001:  return int'($signed(h));
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    // One complete access, starting just after a falling edge with the DUT in IDLE.
    task automatic do_access(input string tag, input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int delay);
        int          nb;
        int          off;
        bit          err;
        bit          done;
        int          stall_n;
        int          req_n;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        nb  = 1 << size[1:0];
        off = int'(addr[1:0]);
        err = !(size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || ((addr % nb) != 0);
        for (int n = 0; n < 4; n++) begin
            ebe[n]       = (n >= off) && (n < off + nb);
            ewd[8*n +: 8] = wd[8*(n % nb) +: 8];
        end
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        stall_n = 0;
        req_n   = 0;
        done    = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (!core_stall_o) begin
                done = 1;
                break;
            end
            stall_n++;
            if (mem_req_o) begin
                req_n++;
                check({tag, " addr"}, mem_addr_o, {addr[31:2], 2'b00});
                check({tag, " be"}, {28'd0, mem_be_o}, {28'd0, ebe});
                if (we) check({tag, " wd"}, mem_wd_o, ewd);
                check({tag, " we"}, {31'd0, mem_we_o}, {31'd0, we});
                if (req_n == delay + 1) begin
                    mem_ready_i = 1'b1;
                    mem_rd_i    = rdata;
                end else begin
                    mem_ready_i = 1'b0;
                    mem_rd_i    = $urandom;
                end
            end else begin
                mem_ready_i = 1'($urandom_range(0, 1));
                mem_rd_i    = $urandom;
            end
            @(negedge clk_i);
        end
        check({tag, " completed"}, {31'd0, done}, 32'd1);
        if (err) exp_rd = 32'd0;
        else if (!we) exp_rd = ref_load(size, addr, rdata);
        check({tag, " err"}, {31'd0, lsu_err_o}, {31'd0, err});
        check({tag, " rd"}, core_rd_o, exp_rd);
        check({tag, " req_in_done"}, {31'd0, mem_req_o}, 32'd0);
        check({tag, " stall_cycles"}, stall_n, err ? 1 : delay + 2);
        check({tag, " req_cycles"}, req_n, err ? 0 : delay + 1);
        core_req_i  = 1'b0;
        mem_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        #1;
        check({tag, " err_cleared"}, {31'd0, lsu_err_o}, 32'd0);
        check({tag, " req_idle"}, {31'd0, mem_req_o}, 32'd0);
        mem_ready_i = 1'b0;
    endtask

    initial begin
        logic        r_we;
        logic [2:0]  r_size;
        n_checks    = 0;
        n_errors    = 0;
        exp_rd      = 32'd0;
        rst_i       = 1'b1;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = 32'd0;
        core_wd_i   = 32'd0;
        mem_rd_i    = 32'd0;
        mem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset req", {31'd0, mem_req_o}, 32'd0);
        check("reset we", {31'd0, mem_we_o}, 32'd0);
        check("reset be", {28'd0, mem_be_o}, 32'd0);
        check("reset addr", mem_addr_o, 32'd0);
        check("reset wd", mem_wd_o, 32'd0);
        check("reset rd", core_rd_o, 32'd0);
        check("reset err", {31'd0, lsu_err_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        do_access("lb_103", 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0);
        check("lb_103 value", exp_rd, 32'hFFFF_FF80);
        do_access("lhu_202", 1'b0, 3'b101, 32'h0000_0202, 32'd0, 32'hBEEF_0000, 0);
        check("lhu_202 value", exp_rd, 32'h0000_BEEF);
        do_access("sb_001", 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'hDEAD_BEEF, 3);
        do_access("lw_006", 1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'h1234_5678, 0);
        do_access("size_011", 1'b0, 3'b011, 32'h0000_0010, 32'd0, 32'h1234_5678, 0);

        // Reset during WAIT with a coincident ready must abandon the store.
        core_req_i  = 1'b1;
        core_we_i   = 1'b1;
        core_size_i = 3'b010;
        core_addr_i = 32'h0000_0040;
        core_wd_i   = 32'hCAFE_F00D;
        @(negedge clk_i);
        #1;
        check("rstwait in_wait", {31'd0, mem_req_o}, 32'd1);
        rst_i       = 1'b1;
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'h5555_AAAA;
        @(negedge clk_i);
        #1;
        exp_rd = 32'd0;
        check("rstwait req", {31'd0, mem_req_o}, 32'd0);
        check("rstwait we", {31'd0, mem_we_o}, 32'd0);
        check("rstwait rd", core_rd_o, 32'd0);
        check("rstwait err", {31'd0, lsu_err_o}, 32'd0);
        check("rstwait stall_idle", {31'd0, core_stall_o}, 32'd1);
        rst_i       = 1'b0;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("rstwait no_retry", {31'd0, mem_req_o}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_size = r_we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            do_access($sformatf("rand%0d", i), r_we, r_size, $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, synchronous active-high reset, sampled on the clk_i rising edge.
REQ-003 SHALL have port core_req_i, input, 1, a load/store request from the core, held until core_stall_o is low.
REQ-004 SHALL have port core_we_i, input, 1, with 1=store and 0=load.
REQ-005 SHALL have port core_size_i, input, 3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; all other codes are illegal.
REQ-006 SHALL have port core_addr_i, input, 32, the byte address (ALU result).
REQ-007 SHALL have port core_wd_i, input, 32, the store data (rs2 value).
REQ-008 SHALL have port core_rd_o, output, 32, the extended load result.
REQ-009 SHALL have port core_stall_o, output, 1, which freezes the core PC while high.
REQ-010 SHALL have port lsu_err_o, output, 1, flagging a misaligned access or illegal size.
REQ-011 SHALL have port mem_req_o, output, 1, the memory access request.
REQ-012 SHALL have port mem_we_o, output, 1, the memory write enable.
REQ-013 SHALL have port mem_be_o, output, 4, the byte enables, where bit n selects byte lane n.
REQ-014 SHALL have port mem_addr_o, output, 32, a word-aligned address with bits[1:0]=00.
REQ-015 SHALL have port mem_wd_o, output, 32, the lane-replicated store data.
REQ-016 SHALL have port mem_rd_i, input, 32, the memory read word.
REQ-017 SHALL have port mem_ready_i, input, 1, which completes the access in the cycle it is high while mem_req_o is high.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-019 SHALL drive core_stall_o = core_req_i AND (state != DONE), combinationally.
REQ-020 SHALL, in IDLE with core_req_i=1 and a legal aligned access, register the address, byte enables, write data, we and size, then go to WAIT.
REQ-021 SHALL treat an access as aligned when: byte always; half requires addr[0]=0; word requires addr[1:0]=00.
REQ-022 SHALL, in IDLE with core_req_i=1 and a misaligned access or illegal size, go to DONE with lsu_err_o=1, mem_req_o=0 and core_rd_o=0, so that no memory access occurs.
REQ-023 SHALL, in WAIT, hold mem_req_o=1 with stable mem_addr_o, mem_be_o, mem_wd_o and mem_we_o until mem_ready_i=1.
REQ-024 SHALL, in WAIT with mem_ready_i=1, register the extended read data (loads) and go to DONE; mem_req_o SHALL be 0 from the next cycle.
REQ-025 SHALL keep core_rd_o, lsu_err_o and state DONE valid for exactly one cycle, then return to IDLE.
REQ-026 SHALL hold core_rd_o unchanged for stores.
REQ-027 SHALL generate byte enables as: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-028 SHALL replicate store data as: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
REQ-029 SHALL extract load data as: the lane at addr[1:0] (byte) or addr[1] (half); sign-extended for LB/LH, zero-extended for LBU/LHU; LW passes the full word.
REQ-030 SHALL guarantee a minimum latency from request to stall release of 2 cycles (IDLE->WAIT->DONE with mem_ready_i high in the first WAIT cycle), with no upper bound (wait states).
REQ-031 SHALL ignore mem_ready_i outside WAIT.
REQ-032 SHALL ignore core_req_i in WAIT and DONE.
REQ-033 SHALL sample a new request only in IDLE, so back-to-back accesses need one IDLE cycle.

Reset
REQ-034 SHALL, on rst_i=1 at the clock edge, set state=IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0000, mem_addr_o=0, mem_wd_o=0, core_rd_o=0 and lsu_err_o=0.
REQ-035 SHALL, on reset asserted in WAIT, abandon the access without a write retry, and ignore a mem_ready_i arriving in the same cycle.
REQ-036 SHALL give rst_i priority over all other inputs.

Verification
REQ-037 SHALL verify: LB at addr 0x103 with mem_rd_i=0x80FF_1234 and ready at 1st WAIT -> mem_addr_o=0x100, be=1000, core_rd_o=0xFFFF_FF80, stall for 2 cycles.
REQ-038 SHALL verify: LHU at addr 0x202 with mem_rd_i=0xBEEF_0000 -> be=1100, core_rd_o=0x0000_BEEF.
REQ-039 SHALL verify: SB at addr 0x001 with wd=0x0000_00AB and ready delayed 3 cycles -> mem_wd_o=0xABAB_ABAB, be=0010, mem_we_o=1, mem_req_o held 4 cycles, stall 5 cycles.
REQ-040 SHALL verify: LW at addr 0x006 -> lsu_err_o=1 for 1 cycle, mem_req_o never asserted, core_rd_o=0.
REQ-041 SHALL verify: size=011 -> lsu_err_o=1, with no memory access.
REQ-042 SHALL verify: rst_i asserted during WAIT with mem_ready_i=1 in the same cycle -> next cycle state IDLE, mem_req_o=0, core_rd_o=0.
